// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame checker.
// Holds the FSM state enum, byte width and a saturating increment.
`timescale 1ns/1ps
package parity_frame_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } state_t;

  function automatic logic [W-1:0] sat_inc(
    input logic [W-1:0] v
  );
    return (&v) ? v : v + W'(1);
  endfunction

endpackage

// File: rtl/parity_frame_checker_accum.sv
// Running XOR accumulator for the data bytes of one frame.
// Ports: clk, reset_n, clr (zero), en (fold d in), d, parity.
`timescale 1ns/1ps
module parity_accum
  import parity_frame_pkg::*;
#(
  parameter int DW = W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] parity
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity <= '0;
    end else if (clr) begin
      parity <= '0;
    end else if (en) begin
      parity <= parity ^ d;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side checker for length-prefixed byte frames with XOR check byte.
// Ports: clk, reset_n, clear, ld, d in; busy, done, ok, parity, remaining, err_cnt out.
`timescale 1ns/1ps
module parity_frame_checker
  import parity_frame_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic         done,
  output logic         ok,
  output logic [W-1:0] parity,
  output logic [W-1:0] remaining,
  output logic [W-1:0] err_cnt
);

  state_t state;
  state_t state_nxt;

  logic take;
  logic acc_clr;
  logic acc_en;
  logic chk_take;
  logic match;

  // clear wins over ld, so a byte arriving with clear is ignored
  assign take     = ld & ~clear;
  assign chk_take = take & (state == CHECK);
  assign match    = (d == parity);

  // IDLE length byte restarts the accumulator
  assign acc_clr = clear | (take & (state == IDLE));
  assign acc_en  = take & (state == DATA);

  parity_accum #(
    .DW(W)
  ) u_accum (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .d      (d),
    .parity (parity)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (ld) begin
      unique case (state)
        IDLE:    state_nxt = (d == '0) ? CHECK : DATA;
        DATA:    state_nxt = (remaining == W'(1)) ? CHECK : DATA;
        CHECK:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    unique case (1'b1)
      (state == DATA):  busy = 1'b1;
      (state == CHECK): busy = 1'b1;
      default:          busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= '0;
    end else if (take) begin
      unique case (state)
        IDLE:    remaining <= d;
        DATA:    remaining <= remaining - W'(1);
        default: remaining <= remaining;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      ok      <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= chk_take;
      if (chk_take) begin
        ok <= match;
        if (!match) begin
          err_cnt <= sat_inc(err_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker.
// Directed frames push expected {ok, err_cnt}; a monitor pops on done.
`timescale 1ns/100ps
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       ld;
  logic [7:0] d;
  logic       busy;
  logic       done;
  logic       ok;
  logic [7:0] parity;
  logic [7:0] remaining;
  logic [7:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_push = 0;

  logic [8:0] exp_q[$];

  parity_frame_checker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .ld       (ld),
    .d        (d),
    .busy     (busy),
    .done     (done),
    .ok       (ok),
    .parity   (parity),
    .remaining(remaining),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    ld = 1'b1;
    d  = b;
  endtask

  task automatic send_chk(input logic [7:0] b, input logic eok,
                          input logic [7:0] eerr);
    exp_q.push_back({eok, eerr});
    n_push++;
    send(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ld    = 1'b0;
      clear = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("done_ok", 32'(ok), 32'(e[8]));
        chk("done_err_cnt", 32'(err_cnt), 32'(e[7:0]));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    ld      = 1'b0;
    d       = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ok", 32'(ok), 32'h0);
    chk("rst_parity", 32'(parity), 32'h0);
    chk("rst_remaining", 32'(remaining), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    reset_n = 1'b1;

    // good frame
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("len_remaining", 32'(remaining), 32'h1);
    chk("busy_data", 32'(busy), 32'h1);
    send_chk(8'h26, 1'b1, 8'h00);
    chk("good_parity", 32'(parity), 32'h26);
    chk("good_remaining", 32'(remaining), 32'h0);
    idle(1);
    chk("good_done", 32'(done), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
    idle(1);
    chk("done_one_cycle", 32'(done), 32'h0);

    // bad then good, back to back
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send_chk(8'h27, 1'b0, 8'h01);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send_chk(8'h26, 1'b1, 8'h01);
    idle(2);

    // empty frames with gaps
    send(8'h00);
    idle(3);
    chk("empty_busy", 32'(busy), 32'h1);
    send_chk(8'h00, 1'b1, 8'h01);
    send(8'h00);
    send_chk(8'h5A, 1'b0, 8'h02);
    idle(2);
    chk("ok_holds", 32'(ok), 32'h0);

    // abort via clear with ld in the same cycle
    send(8'h03);
    send(8'h11);
    send(8'h22);
    clear = 1'b1;
    idle(1);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_parity", 32'(parity), 32'h0);
    chk("clr_remaining", 32'(remaining), 32'h0);
    chk("clr_err_cnt", 32'(err_cnt), 32'h2);
    send(8'h01);
    send(8'hAB);
    send_chk(8'hAB, 1'b1, 8'h02);
    idle(2);

    // asynchronous reset mid-frame
    send(8'h02);
    send(8'h55);
    idle(1);
    chk("pre_rst_parity", 32'(parity), 32'h55);
    #2.3;
    reset_n = 1'b0;
    #0.5;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_ok", 32'(ok), 32'h0);
    chk("arst_parity", 32'(parity), 32'h0);
    chk("arst_remaining", 32'(remaining), 32'h0);
    chk("arst_err_cnt", 32'(err_cnt), 32'h0);
    #0.5;
    reset_n = 1'b1;
    idle(2);

    // saturation: 256 bad frames
    for (int i = 1; i <= 256; i++) begin
      send(8'h01);
      send(8'h01);
      send_chk(8'h00, 1'b0, (i > 255) ? 8'hFF : 8'(i));
    end
    idle(3);
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("done_count", 32'(n_done), 32'(n_push));
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
